// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back sequencer and the source multiplexer.
package wb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaitHilo,
        StWrite
    } wb_state_e;

    localparam int unsigned SEL_ALU  = 0;
    localparam int unsigned SEL_LS   = 1;
    localparam int unsigned SEL_HI   = 2;
    localparam int unsigned SEL_LO   = 3;
    localparam int unsigned SEL_LT   = 4;
    localparam int unsigned SEL_INST = 5;
    localparam int unsigned SEL_E6   = 6;
    localparam int unsigned SEL_E7   = 7;
    localparam int unsigned SEL_E8   = 8;
    localparam int unsigned SEL_E9   = 9;
    localparam int unsigned SEL_EXC  = 10;
    localparam int unsigned SEL_MAX  = 10;

    localparam logic [31:0] EXC_CONST = 32'd227;

    function automatic logic sel_is_hilo(input int unsigned sel);
        return (sel == SEL_HI) || (sel == SEL_LO);
    endfunction

    function automatic logic sel_is_illegal(input int unsigned sel);
        return sel > SEL_MAX;
    endfunction

endpackage

// File: rtl/wb_sequencer.sv
// Write-back sequencer: one register-file write at a time, HI/LO stall while mult/div is busy,
// exception writes pre-empt normal traffic.
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int unsigned          SEL_W   = 4,
    parameter int unsigned          ADDR_W  = 5,
    parameter logic [ADDR_W-1:0]    EXC_REG = ADDR_W'(31),
    parameter int unsigned          STALL_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [SEL_W-1:0]   req_sel,
    input  logic [ADDR_W-1:0]  req_dst,
    input  logic               exc_valid,
    output logic               exc_ack,
    input  logic               md_busy,
    output logic [SEL_W-1:0]   mem_to_reg_sel,
    output logic               reg_write,
    output logic [ADDR_W-1:0]  write_reg,
    output logic               wb_done,
    output logic               sel_error,
    output logic [STALL_W-1:0] stall_cycles
);

    wb_state_e           state_q, state_d;
    logic [SEL_W-1:0]    pend_sel_q, pend_sel_d;
    logic [ADDR_W-1:0]   pend_dst_q, pend_dst_d;
    logic                exc_q, exc_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic                sel_error_q, sel_error_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            pend_sel_q  <= '0;
            pend_dst_q  <= '0;
            exc_q       <= 1'b0;
            sel_q       <= '0;
            dst_q       <= '0;
            stall_q     <= '0;
            sel_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_sel_q  <= pend_sel_d;
            pend_dst_q  <= pend_dst_d;
            exc_q       <= exc_d;
            sel_q       <= sel_d;
            dst_q       <= dst_d;
            stall_q     <= stall_d;
            sel_error_q <= sel_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_sel_d  = pend_sel_q;
        pend_dst_d  = pend_dst_q;
        exc_d       = exc_q;
        sel_d       = sel_q;
        dst_d       = dst_q;
        stall_d     = stall_q;
        sel_error_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (exc_valid) begin
                    state_d = StWrite;
                    exc_d   = 1'b1;
                    sel_d   = SEL_W'(SEL_EXC);
                    dst_d   = EXC_REG;
                end else if (req_valid) begin
                    if (sel_is_illegal(32'(req_sel))) begin
                        // Illegal source: drop the request, flag it, no write.
                        sel_error_d = 1'b1;
                    end else if (sel_is_hilo(32'(req_sel)) && md_busy) begin
                        state_d    = StWaitHilo;
                        pend_sel_d = req_sel;
                        pend_dst_d = req_dst;
                        stall_d    = '0;
                        exc_d      = 1'b0;
                    end else begin
                        state_d = StWrite;
                        exc_d   = 1'b0;
                        sel_d   = req_sel;
                        dst_d   = req_dst;
                    end
                end
            end
            StWaitHilo: begin
                if (stall_q != '1) begin
                    stall_d = stall_q + STALL_W'(1);
                end
                // An exception discards the pending HI/LO request outright.
                if (exc_valid) begin
                    state_d = StWrite;
                    exc_d   = 1'b1;
                    sel_d   = SEL_W'(SEL_EXC);
                    dst_d   = EXC_REG;
                end else if (!md_busy) begin
                    state_d = StWrite;
                    exc_d   = 1'b0;
                    sel_d   = pend_sel_q;
                    dst_d   = pend_dst_q;
                end
            end
            StWrite: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        req_ready      = (state_q == StIdle) && !exc_valid;
        reg_write      = (state_q == StWrite) && (dst_q != '0);
        wb_done        = (state_q == StWrite) && !exc_q;
        exc_ack        = (state_q == StWrite) && exc_q;
        mem_to_reg_sel = sel_q;
        write_reg      = dst_q;
        sel_error      = sel_error_q;
        stall_cycles   = stall_q;
    end

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Write-back sequencer for the multicycle CPU datapath. Accepts one register-file write request at a time from the control unit and stalls HI/LO reads while the mult/div unit is busy. Lets an exception-handler write pre-empt normal traffic. Drives the select lines of the write-back source multiplexer, plus the register-file write enable and destination register, from registered state.

## Interface
- `SEL_W`, 4, width of the write-back source select.
- `ADDR_W`, 5, register-file address width.
- `EXC_REG`, 5'd31, destination register for exception writes.
- `STALL_W`, 8, width of the stall counter.
- `clk`  in  1  system clock. One clock domain; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  control unit presents a write-back request.
- `req_ready`  out  1  sequencer accepts the request this cycle.
- `req_sel`  in  SEL_W  source select for the request, 0..10.
- `req_dst`  in  ADDR_W  destination register.
- `exc_valid`  in  1  exception write request: source 10 (constant 227) to `EXC_REG`; level, held until `exc_ack`.
- `exc_ack`  out  1  one-cycle pulse when the exception write is issued.
- `md_busy`  in  1  mult/div unit is updating HI/LO.
- `mem_to_reg_sel`  out  SEL_W  registered select to the write-back source multiplexer.
- `reg_write`  out  1  register-file write enable, one cycle per write.
- `write_reg`  out  ADDR_W  registered destination register.
- `wb_done`  out  1  one-cycle pulse, aligned with `reg_write`, for a normal request.
- `sel_error`  out  1  one-cycle pulse: an illegal `req_sel` (11..15) was accepted and dropped.
- `stall_cycles`  out  STALL_W  cycle count of the most recent HI/LO stall.

## Operation
- States: IDLE, WAIT_HILO, WRITE.
- IDLE:
  - `req_ready` = `!exc_valid`. A request is accepted on `req_valid && req_ready`; `req_sel` and `req_dst` are captured.
  - If `exc_valid` is high: go to WRITE with sel 10 and dst `EXC_REG`, and raise the exception flag. `exc_ack` pulses in the WRITE cycle.
  - If the accepted sel is 2 (HI) or 3 (LO) and `md_busy` is high: go to WAIT_HILO and clear `stall_cycles` to 0.
  - If the accepted sel is 11..15: pulse `sel_error` in the next cycle, stay in IDLE, perform no write.
  - Otherwise: go to WRITE.
- WAIT_HILO:
  - `req_ready` = 0.
  - `stall_cycles` increments each cycle and saturates at all-ones.
  - When `md_busy` is low, go to WRITE.
  - If `exc_valid` rises: discard the pending request (no `wb_done`) and go to WRITE with the exception write.
- WRITE:
  - `reg_write` = 1 for exactly one cycle, then return to IDLE; `req_ready` = 0 this cycle.
  - If `write_reg` = 0, `reg_write` is forced low, but `wb_done` still pulses.
- `mem_to_reg_sel` and `write_reg` hold their last value outside WRITE; no glitching.

## Timing
- Reset: state IDLE; `req_ready` follows `!exc_valid`; all other outputs 0, including `mem_to_reg_sel`, `write_reg` and `stall_cycles`.
- Accept in cycle N without a stall: `reg_write`/`wb_done` high in N+1. The next accept is possible in N+2.
- Stall: `md_busy` falls in cycle M (sampled low at edge M) → WRITE in M+1.
- Exception and request in the same IDLE cycle: the exception wins and the request is not accepted (`req_ready` = 0).
- Reset asserted mid-operation: the in-flight write is lost and nothing is pulsed.
- Throughput: at most one write every 2 cycles.

## Structure
- Shared package `wb_pkg` holds:
  - the state enum;
  - source constants SEL_ALU=0, SEL_LS=1, SEL_HI=2, SEL_LO=3, SEL_LT=4, SEL_INST=5, SEL_E6..SEL_E9=6..9, SEL_EXC=10, SEL_MAX=10;
  - EXC_CONST=32'd227.
- Single module, no sub-module. The source multiplexer remains a separate block that consumes `mem_to_reg_sel`.

## Test plan
- Request sel=0, dst=8 in cycle 1 with `md_busy`=0 → cycle 2: `reg_write`=1, `mem_to_reg_sel`=0, `write_reg`=8, `wb_done`=1; `req_ready`=1 again in cycle 3.
- Request sel=2, dst=9 with `md_busy` high for 5 cycles → WAIT_HILO; `stall_cycles`=5; write in the cycle after `md_busy` falls, with sel=2.
- `exc_valid` and `req_valid` high together in IDLE → `req_ready`=0; write sel=10, dst=31; `exc_ack`=1; the request is accepted 2 cycles later.
- `exc_valid` asserted during a sel=3 stall → pending request dropped with no `wb_done`; exception write issued the next cycle.
- `req_sel`=12 → `sel_error` pulse, no `reg_write`; `req_sel`=0 with dst=0 → `reg_write`=0, `wb_done`=1.
- `md_busy` held 300 cycles → `stall_cycles` saturates at 255; `reset_n` low mid-stall → all outputs 0, state IDLE.
